rv_div_unit: RTL and testbench

//   Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU) in the execute stage.

---
 rtl/rv_mdu_pkg.sv | 29 ++
 rtl/rv_div_unit_step.sv | 26 ++
 rtl/rv_div_unit.sv | 139 +++++++++++++
 tb/tb_rv_div_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mdu_pkg.sv
// Shared multiply/divide definitions: op encoding, divider FSM states
// and widths. Also used by the decoder and the future multiplier.
package rv_mdu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic logic op_signed(logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_rem(logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/rv_div_unit_step.sv
// One restoring-division step: shift in a dividend bit and
// conditionally subtract the divisor.
module div_step
  import rv_mdu_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W:0]   rem,
  input  logic         dvd_bit,
  input  logic [W-1:0] dvs,
  output logic [W:0]   rem_next,
  output logic         q_bit
);

  logic [W:0] sh;
  logic [W:0] diff;

  always_comb begin
    sh    = {rem[W-1:0], dvd_bit};
    diff  = sh - {1'b0, dvs};
    // rem[W] set means the shifted value cannot fit below the divisor
    q_bit = rem[W] | (sh >= {1'b0, dvs});
    rem_next = q_bit ? diff : sh;
  end

endmodule

// File: rtl/rv_div_unit.sv
// Iterative RV32M divide/remainder unit, radix-2 restoring, with
// valid/ready handshakes on the operand and result sides.
module rv_div_unit
  import rv_mdu_pkg::*;
#(
  parameter int XLEN = rv_mdu_pkg::XLEN,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [RD_W-1:0] rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_wdata,
  output logic [RD_W-1:0] out_rd,
  output logic            out_we,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e state, state_nx;

  logic [CW-1:0]   cnt;
  logic [XLEN:0]   rem;
  logic [XLEN-1:0] dvd;
  logic [XLEN-1:0] dvs;
  logic            is_rem;
  logic            neg_q;
  logic            neg_r;

  logic            accept;
  logic            sgn;
  logic            a_neg;
  logic            b_neg;
  logic            div0;
  logic            ovf;
  logic            special;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] sp_res;
  logic [XLEN:0]   rem_nx;
  logic            q_bit;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  div_step #(.W(XLEN)) u_step (
    .rem      (rem),
    .dvd_bit  (dvd[XLEN-1]),
    .dvs      (dvs),
    .rem_next (rem_nx),
    .q_bit    (q_bit)
  );

  always_comb begin
    sgn     = op_signed(op);
    a_neg   = sgn & rs1_data[XLEN-1];
    b_neg   = sgn & rs2_data[XLEN-1];
    a_mag   = a_neg ? -rs1_data : rs1_data;
    b_mag   = b_neg ? -rs2_data : rs2_data;
    div0    = (rs2_data == '0);
    ovf     = sgn && (rs1_data == MIN_NEG) && (rs2_data == '1);
    special = div0 | ovf;
    // overflow quotient equals the dividend; div-by-zero remainder too
    if (op_rem(op)) sp_res = div0 ? rs1_data : '0;
    else            sp_res = div0 ? '1 : rs1_data;
    q_fix   = neg_q ? -dvd : dvd;
    r_fix   = neg_r ? -rem[XLEN-1:0] : rem[XLEN-1:0];
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign out_we    = out_valid && (out_rd != '0);
  assign accept    = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = special ? DONE : CALC;
      CALC: if (cnt == LAST) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      rem       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      is_rem    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      out_wdata <= '0;
      out_rd    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            out_rd <= rd_in;
            is_rem <= op_rem(op);
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dvd    <= a_mag;
            dvs    <= b_mag;
            rem    <= '0;
            cnt    <= '0;
            if (special) out_wdata <= sp_res;
          end
        end
        CALC: begin
          rem <= rem_nx;
          dvd <= {dvd[XLEN-2:0], q_bit};
          cnt <= cnt + 1'b1;
        end
        FIX: out_wdata <= is_rem ? r_fix : q_fix;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_div_unit.sv
// Randomized and directed bench for rv_div_unit against an
// arithmetic reference model of the RV32M divide rules.
module tb_rv_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_wdata;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        busy;

  int checks = 0;
  int errs = 0;

  rv_div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rd_in     (rd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_wdata (out_wdata),
    .out_rd    (out_rd),
    .out_we    (out_we),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(logic [1:0] o, logic [31:0] a,
                                          logic [31:0] b);
    logic [31:0] q, r;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!o[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return o[1] ? r : q;
  endfunction

  function automatic bit is_special(logic [1:0] o, logic [31:0] a,
                                    logic [31:0] b);
    return (b == 0) ||
           (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Issues one op, waits for the result and checks data, rd, we, latency.
  // Latency is edges after the accepting edge (special: seen at accept).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input string tag);
    logic [31:0] e;
    int n;
    e = ref_div(o, a, b);
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    rs1_data = a;
    rs2_data = b;
    rd_in = rd;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, n, is_special(o, a, b) ? 0 : 33);
    check({tag, " wdata"}, out_wdata, e);
    check({tag, " rd"}, {27'd0, out_rd}, {27'd0, rd});
    check({tag, " we"}, {31'd0, out_we}, {31'd0, rd != 0});
    if (out_ready) begin
      @(posedge clk);
      #1;
      check({tag, " released"}, {30'd0, out_valid, in_ready}, 32'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e, a, b;
    logic [4:0] rd;
    logic [1:0] o;
    bit seen;

    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    op = 2'b00;
    rs1_data = '0;
    rs2_data = '0;
    rd_in = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready/busy/valid/we",
          {28'd0, in_ready, busy, out_valid, out_we}, 32'h8);
    check("reset wdata", out_wdata, 32'd0);
    check("reset rd", {27'd0, out_rd}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(2'b01, 32'd100, 32'd7, 5'd5, "divu 100/7");
    run_op(2'b11, 32'd100, 32'd7, 5'd6, "remu 100/7");
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1, "div -7/2");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2, "rem -7/2");
    run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd3, "div 7/-2");
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd4, "rem 7/-2");
    run_op(2'b01, 32'd5, 32'd0, 5'd7, "divu 5/0");
    run_op(2'b10, 32'd5, 32'd0, 5'd8, "rem 5/0");
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, "div ovf");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, "rem ovf");
    run_op(2'b01, 32'd9, 32'd3, 5'd0, "divu 9/3 x0");

    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 9))
        0: b = 0;
        1: b = $urandom_range(1, 15);
        2: begin b = 32'hFFFF_FFFF; a = 32'h8000_0000; end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      rd = 5'($urandom_range(0, 31));
      run_op(o, a, b, rd, "random");
    end

    // back-pressure in DONE
    out_ready = 1'b0;
    run_op(2'b00, 32'hFFFF_FC18, 32'd7, 5'd12, "bp div");
    e = ref_div(2'b00, 32'hFFFF_FC18, 32'd7);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i == 4);
      op = 2'b01;
      rs1_data = 32'd50;
      rs2_data = 32'd5;
      rd_in = 5'd20;
      @(posedge clk);
      #1;
      check("bp wdata", out_wdata, e);
      check("bp rd", {27'd0, out_rd}, 32'd12);
      check("bp valid/ready", {30'd0, out_valid, in_ready}, 32'd2);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release", {29'd0, out_valid, in_ready, busy}, 32'd2);

    // flush mid-CALC with a competing in_valid
    @(negedge clk);
    in_valid = 1'b1;
    op = 2'b01;
    rs1_data = 32'd1000;
    rs2_data = 32'd3;
    rd_in = 5'd11;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("flush pre busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    in_valid = 1'b1;
    rs1_data = 32'd9;
    rd_in = 5'd13;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush idle", {29'd0, out_valid, in_ready, busy}, 32'd2);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) seen = 1'b1;
    end
    check("flush quiet", {31'd0, seen}, 32'd0);

    // asynchronous reset mid-CALC
    @(negedge clk);
    in_valid = 1'b1;
    op = 2'b00;
    rs1_data = 32'd77;
    rs2_data = 32'd4;
    rd_in = 5'd14;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("arst pre busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst async", {29'd0, out_valid, in_ready, busy}, 32'd2);
    check("arst rd", {27'd0, out_rd}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(2'b11, 32'hDEAD_BEEF, 32'd1000, 5'd31, "post-rst remu");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
